// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame-sequencing FSM for the UART transmitter.
// One CLK cycle is one bit period. A request accepted in IDLE produces
// START, DATA_WIDTH data bits, an optional parity bit and STOP_BITS stop
// bits on the TX mux select. It also gates the serializer and the parity
// calculator. The registered outputs are decoded from the next state, so
// they change on the same edge as the state register.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1   // legal values: 1 or 2
) (
  input  logic       CLK,
  input  logic       RST,          // asynchronous, active-low
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       accept,
  output logic       par_calc_en,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  // TX output mux encodings
  localparam logic [1:0] MUX_START  = 2'b00;  // line driven low
  localparam logic [1:0] MUX_IDLE   = 2'b01;  // line driven high (idle and stop)
  localparam logic [1:0] MUX_DATA   = 2'b10;  // serializer output
  localparam logic [1:0] MUX_PARITY = 2'b11;  // parity calculator output

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             par_lat_q, par_lat_d;
  logic             ser_en_q, ser_en_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  // Next-state and counter logic; accept is combinational from the IDLE state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_lat_d  = par_lat_q;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          accept    = 1'b1;
          par_lat_d = PAR_EN;   // parity choice is frozen for the whole frame
          state_d   = S_START;
        end
      end
      S_START: begin
        bit_cnt_d = '0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          stop_cnt_d = 1'b0;
          state_d    = par_lat_q ? S_PARITY : S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        stop_cnt_d = 1'b0;
        state_d    = S_STOP;
      end
      S_STOP: begin
        if (stop_cnt_q == STOP_LAST) begin
          state_d = S_IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        // Unreachable encodings fall back to a clean idle line.
        state_d    = S_IDLE;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        par_lat_d  = 1'b0;
      end
    endcase
  end

  assign par_calc_en = accept & PAR_EN;

  // Moore output decode from the next state, registered alongside it.
  always_comb begin
    mux_sel_d    = MUX_IDLE;
    ser_en_d     = 1'b0;
    busy_d       = 1'b1;
    frame_done_d = 1'b0;
    case (state_d)
      S_START:  mux_sel_d = MUX_START;
      S_DATA: begin
        mux_sel_d = MUX_DATA;
        ser_en_d  = 1'b1;
      end
      S_PARITY: mux_sel_d = MUX_PARITY;
      S_STOP: begin
        mux_sel_d    = MUX_IDLE;
        frame_done_d = (stop_cnt_d == STOP_LAST);
      end
      default:  busy_d = 1'b0;   // IDLE (and any recovered state)
    endcase
  end

  // State, counters and registered outputs; reset forces an idle-high line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_lat_q    <= 1'b0;
      ser_en_q     <= 1'b0;
      mux_sel_q    <= MUX_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking ones here would make results depend on statement order.
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      par_lat_q    <= par_lat_d;
      ser_en_q     <= ser_en_d;
      mux_sel_q    <= mux_sel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_en     = ser_en_q;
  assign mux_sel    = mux_sel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: one 8-data/1-stop instance and one
// 7-data/2-stop instance run side by side. A reference model expands each
// accepted request into its list of line symbols and compares every cycle.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] dv  = '0;
  logic [1:0] pe  = '0;

  logic [1:0] acc, pce, sen, bsy, fdn;
  logic [1:0] mux [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut_a (
    .CLK(CLK), .RST(RST), .Data_Valid(dv[0]), .PAR_EN(pe[0]),
    .accept(acc[0]), .par_calc_en(pce[0]), .ser_en(sen[0]),
    .mux_sel(mux[0]), .busy(bsy[0]), .frame_done(fdn[0])
  );

  uart_tx_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) u_dut_b (
    .CLK(CLK), .RST(RST), .Data_Valid(dv[1]), .PAR_EN(pe[1]),
    .accept(acc[1]), .par_calc_en(pce[1]), .ser_en(sen[1]),
    .mux_sel(mux[1]), .busy(bsy[1]), .frame_done(fdn[1])
  );

  // Reference model: the remaining symbols (mux codes) of the frame in flight.
  int    dw   [2] = '{8, 7};
  int    sb   [2] = '{1, 2};
  string name [2] = '{"8x1", "7x2"};
  int    sym  [2][0:15];
  int    len  [2] = '{0, 0};
  int    pos  [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A frame is: start(0), data(2) x width, optional parity(3), stop(1) x count.
  task automatic build_frame(input int i, input logic par);
    len[i] = 0;
    sym[i][len[i]++] = 0;
    for (int k = 0; k < dw[i]; k++) sym[i][len[i]++] = 2;
    if (par) sym[i][len[i]++] = 3;
    for (int k = 0; k < sb[i]; k++) sym[i][len[i]++] = 1;
    pos[i] = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic step(input logic [1:0] dv_i, input logic [1:0] pe_i);
    @(negedge CLK);
    dv = dv_i;
    pe = pe_i;
    #1;
    for (int i = 0; i < 2; i++) begin
      int   e_mux;
      logic e_busy, e_ser, e_fd, e_acc, e_pce;
      if (pos[i] < len[i]) begin
        e_mux  = sym[i][pos[i]];
        e_busy = 1'b1;
        e_ser  = (e_mux == 2);
        e_fd   = (pos[i] == len[i] - 1);
        e_acc  = 1'b0;
        e_pce  = 1'b0;
      end else begin
        e_mux  = 1;
        e_busy = 1'b0;
        e_ser  = 1'b0;
        e_fd   = 1'b0;
        e_acc  = dv_i[i];
        e_pce  = dv_i[i] & pe_i[i];
      end
      check({name[i], " mux_sel"},     32'(mux[i]), 32'(e_mux));
      check({name[i], " busy"},        32'(bsy[i]), 32'(e_busy));
      check({name[i], " ser_en"},      32'(sen[i]), 32'(e_ser));
      check({name[i], " frame_done"},  32'(fdn[i]), 32'(e_fd));
      check({name[i], " accept"},      32'(acc[i]), 32'(e_acc));
      check({name[i], " par_calc_en"}, 32'(pce[i]), 32'(e_pce));
      if (pos[i] < len[i]) pos[i]++;
      else if (dv_i[i]) build_frame(i, pe_i[i]);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 2'($urandom));
  endtask

  // Assert reset between clock edges and check the line drops to idle at once.
  task automatic reset_now();
    @(negedge CLK);
    dv  = '0;
    RST = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check({name[i], " rst mux_sel"}, 32'(mux[i]), 32'd1);
      check({name[i], " rst busy"},    32'(bsy[i]), 32'd0);
      check({name[i], " rst ser_en"},  32'(sen[i]), 32'd0);
      check({name[i], " rst frm_done"}, 32'(fdn[i]), 32'd0);
      len[i] = 0;
      pos[i] = 0;
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    // Power-on reset, then the block must idle without a request.
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle_steps(4);

    // Plain frames: no parity, then parity (PAR_EN toggles while busy).
    step(2'b11, 2'b00);
    idle_steps(16);
    step(2'b11, 2'b11);
    idle_steps(16);

    // Request pulsed mid-frame must be ignored.
    step(2'b11, 2'b01);
    idle_steps(3);
    step(2'b11, 2'b10);
    idle_steps(16);

    // Request held high: back-to-back frames with one idle cycle between.
    for (int k = 0; k < 40; k++) step(2'b11, 2'($urandom));
    idle_steps(16);

    // Reset in the middle of the data bits, then stay idle until requested.
    step(2'b11, 2'b11);
    idle_steps(4);
    reset_now();
    idle_steps(5);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      logic [1:0] d;
      d[0] = ($urandom_range(0, 3) == 0);
      d[1] = ($urandom_range(0, 3) == 0);
      step(d, 2'($urandom));
    end
    idle_steps(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
